hv_class_trainer: RTL and testbench
===================================

// Module: hv_class_trainer
// PURPOSE
// Training-side counterpart of the similarity classifier: builds the class prototype HVs it consumes.
// Bundles encoded query HVs per label (non-seizure / seizure) into per-dimension bit counters.
// On finalize, thresholds each counter by majority to produce ns_hv / s_hv.
// Sits after the encoder in training mode; outputs feed similarity.ns_hv / similarity.s_hv.
// PARAMETERS
// DIMENSIONS  10  hypervector width in bits
// CNT_W       8   counter width; max samples per class = 2**CNT_W-1
// PORTS
// clk         in   1           rising-edge clock
// rst         in   1           synchronous, active-high reset
// clear       in   1           start new training run: zero all counters/prototypes
// in_valid    in   1           in_hv/in_label valid
// in_ready    out  1           sample accepted when in_valid && in_ready
// in_hv       in   DIMENSIONS  encoded sample HV
// in_label    in   1           0 = non-seizure, 1 = seizure
// finalize    in   1           request prototype computation (1-cycle pulse, sampled in ACCUM)
// ns_hv       out  DIMENSIONS  non-seizure prototype
// s_hv        out  DIMENSIONS  seizure prototype
// proto_valid out  1           ns_hv/s_hv are current
// sat_err     out  1           sticky: a sample was dropped because its class count was full
// BEHAVIOUR
// - Reset: FSM=ACCUM; all bit counters and n_ns/n_s = 0; ns_hv=s_hv=0; proto_valid=0; sat_err=0; in_ready=1.
// - FSM states: ACCUM -> FIN_NS -> FIN_S -> ACCUM. in_ready=1 only in ACCUM.
// - ACCUM, accepted sample: for label L, if n_L < 2**CNT_W-1, then n_L++ and cnt_L[d]++ wherever in_hv[d]=1 (next cycle).
//   Otherwise the sample is dropped, counters unchanged, sat_err<=1.
// - Bit counters never overflow: cnt_L[d] <= n_L always holds.
// - finalize in ACCUM: go to FIN_NS next cycle; proto_valid<=0.
//   A sample accepted in the same cycle IS included in the result.
// - FIN_NS: ns_hv[d] <= (2*cnt_ns[d] > n_ns); width CNT_W+1 compare. Tie -> 0; n_ns=0 -> all zeros.
// - FIN_S: same rule for s_hv; proto_valid<=1; FSM->ACCUM.
// - Latency: finalize at cycle t -> proto_valid=1 and both prototypes stable at t+3.
//   In FIN states, in_valid is ignored (not accepted) and finalize is ignored.
// - After finalize, counters retain state: further samples continue bundling.
//   Prototypes and proto_valid hold until the next finalize or clear.
// - clear (any state, priority below rst, above all else):
//   Next cycle same state as reset except sat_err is also cleared. A sample offered with clear is not accepted.
// - rst mid-finalize: FSM->ACCUM, all outputs to reset values; no partial prototype is kept.
// STRUCTURE
// - hdc_pkg: DIMENSIONS default, LABEL_NS=1'b0 / LABEL_S=1'b1, trainer_state_t enum {ACCUM,FIN_NS,FIN_S}.
// - Sub-module hv_accumulator #(DIMENSIONS,CNT_W), instanced once per class.
//   Holds the sample count plus the per-dimension bit counters.
//   Interfaces: inc/hv inputs, clr input, full output, majority-threshold output vector.
// - Top holds FSM, label steering, prototype registers, sat_err.
// TESTING (DIMENSIONS=10, CNT_W=4)
// - Reset: rst 2 cycles -> ns_hv=s_hv=0, proto_valid=0, in_ready=1, sat_err=0.
// - Majority: NS samples 0110000100, 0110110110, 1110011111; finalize
//   -> ns_hv=0110010110, s_hv=0000000000, proto_valid rises 3 cycles after finalize.
// - Tie: clear; S samples 1111111111, 0000000000; finalize -> s_hv=0000000000.
//   Add S sample 1111111111 and finalize again -> s_hv=1111111111.
// - Saturation: clear; 16 S samples of 1111111111 -> 15 accepted, 16th dropped.
//   sat_err=1; finalize -> s_hv=1111111111.
// - Same-cycle: NS sample 1111111111 with finalize high on an empty trainer -> ns_hv=1111111111.
//   in_ready=0 for 2 cycles.
// - Reset in FIN_NS: rst asserted 1 cycle after finalize
//   -> ns_hv=s_hv=0, proto_valid=0, counters empty (a later finalize gives all-zero prototypes).

Source files
------------

// File: rtl/hv_class_trainer_pkg.sv
// Shared types and constants for the hypervector class trainer.
package hv_class_trainer_pkg;

    localparam int DIMENSIONS_DEF = 10;
    localparam int CNT_W_DEF      = 8;

    localparam logic LABEL_NS = 1'b0;
    localparam logic LABEL_S  = 1'b1;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FIN_NS = 2'd1,
        FIN_S  = 2'd2
    } trainer_state_t;

    // Strict majority: a dimension is set only when more than half of the
    // bundled samples had it set. The doubled count gets one extra bit so the
    // comparison can never wrap; a tie resolves to 0.
    function automatic logic majority_bit(input logic [31:0] cnt, input logic [31:0] n);
        logic [32:0] twice_cnt;
        logic [32:0] n_ext;
        twice_cnt = {cnt, 1'b0};
        n_ext     = {1'b0, n};
        return (twice_cnt > n_ext);
    endfunction

endpackage

// File: rtl/hv_class_trainer_if.sv
// Sample stream into the trainer: one encoded HV plus its class label.
interface hv_class_trainer_if #(
    parameter int DIMENSIONS = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIMENSIONS-1:0] in_hv;
    logic                  in_label;

    modport master (
        output in_valid,
        output in_hv,
        output in_label,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_hv,
        input  in_label,
        output in_ready
    );
endinterface

// File: rtl/hv_class_trainer_accumulator.sv
// Per-class bundling store: a sample counter plus one bit counter per
// dimension. Each counter only increments while the sample count is below
// its maximum, so no bit counter can ever exceed the sample count.
module hv_class_trainer_accumulator
    import hv_class_trainer_pkg::*;
#(
    parameter int DIMENSIONS = DIMENSIONS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    input  logic [DIMENSIONS-1:0] hv,
    output logic                  full,
    output logic [DIMENSIONS-1:0] maj
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] n_r;
    logic [CNT_W-1:0] cnt_r [DIMENSIONS];

    assign full = (n_r == CNT_MAX);

    // Sample count and per-dimension counters; cleared by reset or a new run.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            n_r <= '0;
            for (int d = 0; d < DIMENSIONS; d++) begin
                cnt_r[d] <= '0;
            end
        end else if (inc && !full) begin
            n_r <= n_r + CNT_ONE;
            for (int d = 0; d < DIMENSIONS; d++) begin
                if (hv[d]) begin
                    cnt_r[d] <= cnt_r[d] + CNT_ONE;
                end
            end
        end
    end

    // Majority threshold of every dimension against the current sample count.
    always_comb begin
        maj = '0;
        for (int d = 0; d < DIMENSIONS; d++) begin
            maj[d] = majority_bit(32'(cnt_r[d]), 32'(n_r));
        end
    end

endmodule

// File: rtl/hv_class_trainer.sv
// Training-side prototype builder: bundles labelled sample HVs into two
// per-class accumulators and, on finalize, latches their majority vectors
// into the non-seizure and seizure prototypes over two cycles.
module hv_class_trainer
    import hv_class_trainer_pkg::*;
#(
    parameter int DIMENSIONS = DIMENSIONS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    hv_class_trainer_if.slave     smp,
    input  logic                  finalize,
    output logic [DIMENSIONS-1:0] ns_hv,
    output logic [DIMENSIONS-1:0] s_hv,
    output logic                  proto_valid,
    output logic                  sat_err
);

    trainer_state_t        state_r;
    trainer_state_t        state_nxt_s;
    logic                  in_ready_r;
    logic                  accept_s;
    logic                  inc_ns_s;
    logic                  inc_s_s;
    logic                  drop_s;
    logic                  full_ns_s;
    logic                  full_s_s;
    logic [DIMENSIONS-1:0] maj_ns_s;
    logic [DIMENSIONS-1:0] maj_s_s;

    assign smp.in_ready = in_ready_r;

    // Next-state: finalize starts the two-cycle prototype sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ACCUM: begin
                if (finalize) begin
                    state_nxt_s = FIN_NS;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            FIN_NS:  state_nxt_s = FIN_S;
            FIN_S:   state_nxt_s = ACCUM;
            default: state_nxt_s = ACCUM;
        endcase
    end

    // Sample acceptance and label steering; a full class drops the sample.
    always_comb begin
        accept_s = 1'b0;
        inc_ns_s = 1'b0;
        inc_s_s  = 1'b0;
        drop_s   = 1'b0;
        if ((state_r == ACCUM) && in_ready_r && smp.in_valid && !clear) begin
            accept_s = 1'b1;
            if (smp.in_label == LABEL_S) begin
                if (full_s_s) begin
                    drop_s = 1'b1;
                end else begin
                    inc_s_s = 1'b1;
                end
            end else begin
                if (full_ns_s) begin
                    drop_s = 1'b1;
                end else begin
                    inc_ns_s = 1'b1;
                end
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // State register; ready is registered from the next state so it is
    // high exactly while the FSM sits in ACCUM.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_r    <= ACCUM;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ACCUM);
        end
    end

    // Prototype registers: invalidated on finalize, filled one class per cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ns_hv       <= '0;
            s_hv        <= '0;
            proto_valid <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (finalize) begin
                        proto_valid <= 1'b0;
                    end
                end
                FIN_NS: begin
                    ns_hv <= maj_ns_s;
                end
                FIN_S: begin
                    s_hv        <= maj_s_s;
                    proto_valid <= 1'b1;
                end
                default: begin
                    proto_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky saturation flag; only a new run or reset clears it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sat_err <= 1'b0;
        end else if (accept_s && drop_s) begin
            sat_err <= 1'b1;
        end
    end

    hv_class_trainer_accumulator #(
        .DIMENSIONS (DIMENSIONS),
        .CNT_W      (CNT_W)
    ) u_acc_ns (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (inc_ns_s),
        .hv   (smp.in_hv),
        .full (full_ns_s),
        .maj  (maj_ns_s)
    );

    hv_class_trainer_accumulator #(
        .DIMENSIONS (DIMENSIONS),
        .CNT_W      (CNT_W)
    ) u_acc_s (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (inc_s_s),
        .hv   (smp.in_hv),
        .full (full_s_s),
        .maj  (maj_s_s)
    );

endmodule

// File: tb/tb_hv_class_trainer.sv
// Self-checking bench for hv_class_trainer (DIMENSIONS=10, CNT_W=4).
// The reference keeps, per class, how many samples were bundled and how
// many of them had each dimension set, and derives prototypes by majority.
module tb_hv_class_trainer;

    localparam int D     = 10;
    localparam int CW    = 4;
    localparam int N_MAX = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         finalize = 1'b0;
    logic [D-1:0] ns_hv;
    logic [D-1:0] s_hv;
    logic         proto_valid;
    logic         sat_err;

    int checks = 0;
    int errors = 0;

    // reference state
    int           n_m [2];
    int           ones_m [2][D];
    logic [D-1:0] ns_m;
    logic [D-1:0] s_m;
    logic         pv_m;
    logic         sat_m;

    hv_class_trainer_if #(.DIMENSIONS(D)) smp ();

    hv_class_trainer #(.DIMENSIONS(D), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .smp         (smp),
        .finalize    (finalize),
        .ns_hv       (ns_hv),
        .s_hv        (s_hv),
        .proto_valid (proto_valid),
        .sat_err     (sat_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ns_hv"},       32'(ns_hv),        32'(ns_m));
        check({tag, ".s_hv"},        32'(s_hv),         32'(s_m));
        check({tag, ".proto_valid"}, 32'(proto_valid),  32'(pv_m));
        check({tag, ".sat_err"},     32'(sat_err),      32'(sat_m));
        check({tag, ".in_ready"},    32'(smp.in_ready), 32'd1);
    endtask

    task automatic model_clear();
        for (int l = 0; l < 2; l++) begin
            n_m[l] = 0;
            for (int d = 0; d < D; d++) ones_m[l][d] = 0;
        end
        ns_m  = '0;
        s_m   = '0;
        pv_m  = 1'b0;
        sat_m = 1'b0;
    endtask

    task automatic model_add(input logic [D-1:0] hv, input logic lbl);
        int l;
        l = lbl ? 1 : 0;
        if (n_m[l] < N_MAX) begin
            n_m[l]++;
            for (int d = 0; d < D; d++) if (hv[d]) ones_m[l][d]++;
        end else begin
            sat_m = 1'b1;
        end
    endtask

    function automatic logic [D-1:0] model_proto(input int l);
        logic [D-1:0] p;
        for (int d = 0; d < D; d++) p[d] = (2 * ones_m[l][d] > n_m[l]);
        return p;
    endfunction

    task automatic send(input logic [D-1:0] hv, input logic lbl);
        smp.in_valid = 1'b1;
        smp.in_hv    = hv;
        smp.in_label = lbl;
        step();
        smp.in_valid = 1'b0;
        model_add(hv, lbl);
        check_outputs("send");
    endtask

    // Finalize (optionally with a same-cycle sample); junk is driven on
    // in_valid/finalize during the FIN cycles and must be ignored.
    task automatic do_finalize(input logic with_sample, input logic [D-1:0] hv, input logic lbl);
        finalize     = 1'b1;
        smp.in_valid = with_sample;
        smp.in_hv    = hv;
        smp.in_label = lbl;
        step();
        if (with_sample) model_add(hv, lbl);
        pv_m = 1'b0;
        check("fin1.in_ready",    32'(smp.in_ready), 32'd0);
        check("fin1.proto_valid", 32'(proto_valid),  32'd0);
        finalize     = 1'($urandom_range(0, 1));
        smp.in_valid = 1'b1;
        smp.in_hv    = D'($urandom);
        smp.in_label = 1'($urandom_range(0, 1));
        step();
        check("fin2.in_ready",    32'(smp.in_ready), 32'd0);
        check("fin2.proto_valid", 32'(proto_valid),  32'd0);
        step();
        finalize     = 1'b0;
        smp.in_valid = 1'b0;
        ns_m = model_proto(0);
        s_m  = model_proto(1);
        pv_m = 1'b1;
        check_outputs("fin3");
    endtask

    task automatic do_clear();
        clear        = 1'b1;
        smp.in_valid = 1'b1;
        smp.in_hv    = D'($urandom);
        smp.in_label = 1'($urandom_range(0, 1));
        step();
        clear        = 1'b0;
        smp.in_valid = 1'b0;
        model_clear();
        check_outputs("clear");
    endtask

    initial begin
        logic [D-1:0] all1;
        logic [D-1:0] all0;
        all1 = '1;
        all0 = '0;
        smp.in_valid = 1'b0;
        smp.in_hv    = '0;
        smp.in_label = 1'b0;
        model_clear();

        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_outputs("reset");

        // majority
        send(10'b0110000100, 1'b0);
        send(10'b0110110110, 1'b0);
        send(10'b1110011111, 1'b0);
        do_finalize(1'b0, all0, 1'b0);
        check("maj.ns_const", 32'(ns_hv), 32'(10'b0110010110));
        check("maj.s_const",  32'(s_hv),  32'd0);

        // tie, then break it
        do_clear();
        send(all1, 1'b1);
        send(all0, 1'b1);
        do_finalize(1'b0, all0, 1'b0);
        check("tie.s_const", 32'(s_hv), 32'd0);
        send(all1, 1'b1);
        do_finalize(1'b0, all0, 1'b0);
        check("tie2.s_const", 32'(s_hv), 32'(10'h3FF));

        // saturation
        do_clear();
        for (int i = 0; i < 15; i++) send(all1, 1'b1);
        check("sat15.sat_err", 32'(sat_err), 32'd0);
        send(all1, 1'b1);
        check("sat16.sat_err", 32'(sat_err), 32'd1);
        send(all0, 1'b1);
        do_finalize(1'b0, all0, 1'b0);
        check("sat.s_const", 32'(s_hv), 32'(10'h3FF));

        // same-cycle sample with finalize on an empty trainer
        do_clear();
        do_finalize(1'b1, all1, 1'b0);
        check("same.ns_const", 32'(ns_hv), 32'(10'h3FF));

        // reset one cycle after finalize
        do_clear();
        send(all1, 1'b0);
        send(all1, 1'b1);
        finalize = 1'b1;
        step();
        finalize = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        check_outputs("rst_fin");
        do_finalize(1'b0, all0, 1'b0);
        check("rst_fin.ns_const", 32'(ns_hv), 32'd0);
        check("rst_fin.s_const",  32'(s_hv),  32'd0);

        // randomized traffic
        do_clear();
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 15) begin
                send(D'($urandom), 1'($urandom_range(0, 1)));
            end else if (r < 17) begin
                step();
                check_outputs("idle");
            end else if (r < 19) begin
                do_finalize(1'($urandom_range(0, 1)), D'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                do_clear();
            end
        end
        do_finalize(1'b0, all0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
